// File: rtl/data_memory_io.sv
// Data-memory stage: word-addressed RAM with combinational reads plus an IO page at 0xFF00.
// Define DMEM_IO_TIMER_EN to build the countdown timer at 0xFF03/0xFF04.
module data_memory_io #(
   parameter int N      = 16,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic [N-1:0] Data_ad,
   input  logic [N-1:0] Data_write_data,
   input  logic         Data_write,
   output logic [N-1:0] Data_out,
   input  logic [N-1:0] Switch_in,
   output logic [N-1:0] Led_out,
   output logic         Timer_irq
);

   localparam logic [7:0] IO_PAGE = 8'hFF;

   logic         is_io;
   logic [7:0]   io_off;
   logic         wr_en;
   logic         ram_we, led_we, cyc_we;
   logic [N-1:0] mem_q [DEPTH];
   logic [N-1:0] led_q, led_d;
   logic [N-1:0] sw_meta_q, sw_sync_q;
   logic [N-1:0] cyc_q, cyc_d;
   logic [N-1:0] timer_cnt_rd, timer_stat_rd;

   assign is_io  = (Data_ad[N-1 -: 8] == IO_PAGE);
   assign io_off = Data_ad[7:0];
   // A store that overlaps reset is dropped everywhere, RAM included.
   assign wr_en  = Data_write & Reset;
   assign ram_we = wr_en & ~is_io;
   assign led_we = wr_en & is_io & (io_off == 8'h00);
   assign cyc_we = wr_en & is_io & (io_off == 8'h02);

   always_ff @(posedge Clock) begin
      if (ram_we) mem_q[Data_ad[ADDR_W-1:0]] <= Data_write_data;
   end

   always_comb begin
      led_d = led_we ? Data_write_data : led_q;
      cyc_d = cyc_we ? Data_write_data : cyc_q + N'(1);
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         led_q     <= '0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
         cyc_q     <= '0;
      end else begin
         led_q     <= led_d;
         sw_meta_q <= Switch_in;
         sw_sync_q <= sw_meta_q;
         cyc_q     <= cyc_d;
      end
   end

`ifdef DMEM_IO_TIMER_EN
   logic         tmr_ld_we, tmr_st_we, tmr_expire;
   logic [N-1:0] tmr_cnt_q, tmr_cnt_d, tmr_rld_q, tmr_rld_d;
   logic         tmr_auto_q, tmr_auto_d, tmr_exp_q, tmr_exp_d;

   assign tmr_ld_we = wr_en & is_io & (io_off == 8'h03);
   assign tmr_st_we = wr_en & is_io & (io_off == 8'h04);

   always_comb begin
      tmr_cnt_d  = tmr_cnt_q;
      tmr_rld_d  = tmr_rld_q;
      tmr_auto_d = tmr_auto_q;
      tmr_exp_d  = tmr_exp_q;
      tmr_expire = 1'b0;
      if (tmr_ld_we) begin
         tmr_cnt_d = Data_write_data;
         tmr_rld_d = Data_write_data;
      end else if (tmr_cnt_q != '0) begin
         tmr_cnt_d = tmr_cnt_q - N'(1);
         if (tmr_cnt_q == N'(1)) begin
            tmr_expire = 1'b1;
            if (tmr_auto_q) tmr_cnt_d = tmr_rld_q;
         end
      end
      if (tmr_st_we) begin
         tmr_auto_d = Data_write_data[1];
         if (Data_write_data[0]) tmr_exp_d = 1'b0;
      end
      // Expiry overrides a simultaneous write-1-to-clear.
      if (tmr_expire) tmr_exp_d = 1'b1;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         tmr_cnt_q  <= '0;
         tmr_rld_q  <= '0;
         tmr_auto_q <= 1'b0;
         tmr_exp_q  <= 1'b0;
      end else begin
         tmr_cnt_q  <= tmr_cnt_d;
         tmr_rld_q  <= tmr_rld_d;
         tmr_auto_q <= tmr_auto_d;
         tmr_exp_q  <= tmr_exp_d;
      end
   end

   assign timer_cnt_rd  = tmr_cnt_q;
   assign timer_stat_rd = {{(N-2){1'b0}}, tmr_auto_q, tmr_exp_q};
   assign Timer_irq     = tmr_exp_q;
`else
   assign timer_cnt_rd  = '0;
   assign timer_stat_rd = '0;
   assign Timer_irq     = 1'b0;
`endif

   always_comb begin
      Data_out = '0;
      if (!is_io) begin
         Data_out = mem_q[Data_ad[ADDR_W-1:0]];
      end else begin
         case (io_off)
            8'h00:   Data_out = led_q;
            8'h01:   Data_out = sw_sync_q;
            8'h02:   Data_out = cyc_q;
            8'h03:   Data_out = timer_cnt_rd;
            8'h04:   Data_out = timer_stat_rd;
            default: Data_out = '0;
         endcase
      end
   end

   assign Led_out = led_q;

endmodule

// File: tb/tb_data_memory_io.sv
// Self-checking bench for data_memory_io: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_data_memory_io;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic [15:0] Data_ad = '0;
   logic [15:0] Data_write_data = '0;
   logic        Data_write = 1'b0;
   logic [15:0] Data_out;
   logic [15:0] Switch_in = '0;
   logic [15:0] Led_out;
   logic        Timer_irq;

   data_memory_io dut (
      .Clock(Clock), .Reset(Reset), .Data_ad(Data_ad),
      .Data_write_data(Data_write_data), .Data_write(Data_write),
      .Data_out(Data_out), .Switch_in(Switch_in), .Led_out(Led_out),
      .Timer_irq(Timer_irq)
   );

   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_bad = 0;
   bit run_cmp = 1'b0;

   // ---------------- behavioural model ----------------
   logic [15:0] ram_m [int];
   logic [15:0] led_m = '0, sw_new_m = '0, sw_vis_m = '0, cyc_m = '0;
   logic [15:0] tcount_m = '0, treload_m = '0;
   logic        tauto_m = 1'b0, texp_m = 1'b0;

   function automatic void model_reset();
      led_m = '0; sw_new_m = '0; sw_vis_m = '0; cyc_m = '0;
      tcount_m = '0; treload_m = '0; tauto_m = 1'b0; texp_m = 1'b0;
   endfunction

   function automatic logic [15:0] model_read(input logic [15:0] a, output bit known);
      known = 1'b1;
      if (a[15:8] == 8'hFF) begin
         case (a[7:0])
            8'h00: return led_m;
            8'h01: return sw_vis_m;
            8'h02: return cyc_m;
`ifdef DMEM_IO_TIMER_EN
            8'h03: return tcount_m;
            8'h04: return {14'd0, tauto_m, texp_m};
`endif
            default: return 16'h0000;
         endcase
      end
      if (ram_m.exists(int'(a[7:0]))) return ram_m[int'(a[7:0])];
      known = 1'b0;
      return 16'h0000;
   endfunction

   always @(negedge Reset) model_reset();

   always @(posedge Clock) begin
      if (!Reset) begin
         model_reset();
      end else begin
         logic        io, w;
         logic [15:0] wd;
         bit          expire;
         io = (Data_ad[15:8] == 8'hFF);
         w = Data_write;
         wd = Data_write_data;
         if (w && !io) ram_m[int'(Data_ad[7:0])] = wd;
         if (w && io && Data_ad[7:0] == 8'h00) led_m = wd;
         sw_vis_m = sw_new_m;
         sw_new_m = Switch_in;
         if (w && io && Data_ad[7:0] == 8'h02) cyc_m = wd;
         else cyc_m = cyc_m + 16'd1;
`ifdef DMEM_IO_TIMER_EN
         expire = 1'b0;
         if (w && io && Data_ad[7:0] == 8'h03) begin
            tcount_m = wd;
            treload_m = wd;
         end else if (tcount_m != 0) begin
            tcount_m = tcount_m - 16'd1;
            if (tcount_m == 0) begin
               expire = 1'b1;
               if (tauto_m) tcount_m = treload_m;
            end
         end
         if (w && io && Data_ad[7:0] == 8'h04) begin
            if (wd[0]) texp_m = 1'b0;
            tauto_m = wd[1];
         end
         if (expire) texp_m = 1'b1;
`else
         expire = 1'b0;
         if (expire) texp_m = 1'b1;
`endif
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge Clock) begin
      if (run_cmp) begin
         logic [15:0] e;
         bit known;
         e = model_read(Data_ad, known);
         if (known) check("cmp_data_out", Data_out, e);
         check("cmp_led", Led_out, led_m);
         check("cmp_irq", {15'd0, Timer_irq}, {15'd0, texp_m});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic setin(input logic [15:0] a, input logic [15:0] d, input logic w);
      Data_ad = a;
      Data_write_data = d;
      Data_write = w;
      #1;
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   initial begin
      // reset / cycle counter start
      repeat (3) @(posedge Clock);
      #1 Reset = 1'b1;
      run_cmp = 1'b1;
      setin(16'hFF00, 16'h0, 1'b0);
      check("rst_led_read", Data_out, 16'h0000);
      check("rst_led_out", Led_out, 16'h0000);
      setin(16'hFF02, 16'h0, 1'b0);
      check("rst_cycle", Data_out, 16'h0000);
      repeat (5) tick();
      check("cycle_5", Data_out, 16'h0005);

      // RAM write, read-during-write, alias
      setin(16'h0012, 16'h1111, 1'b1); tick();
      setin(16'h0012, 16'hBEEF, 1'b1);
      check("ram_rdw_old", Data_out, 16'h1111);
      tick();
      setin(16'h0012, 16'h0, 1'b0);
      check("ram_read", Data_out, 16'hBEEF);
      setin(16'h0112, 16'h0, 1'b0);
      check("ram_alias", Data_out, 16'hBEEF);

      // LED, RO switch, unmapped
      setin(16'hFF00, 16'h00A5, 1'b1); tick();
      check("led_write", Led_out, 16'h00A5);
      setin(16'hFF01, 16'hFFFF, 1'b1); tick();
      setin(16'hFF01, 16'h0, 1'b0);
      check("switch_ro", Data_out, 16'h0000);
      setin(16'hFF07, 16'h0, 1'b0);
      check("unmapped", Data_out, 16'h0000);

      // switch synchroniser latency
      setin(16'hFF01, 16'h0, 1'b0);
      Switch_in = 16'h1234;
      tick();
      check("sw_edge1", Data_out, 16'h0000);
      tick();
      check("sw_edge2", Data_out, 16'h1234);

      // cycle load and wrap
      setin(16'hFF02, 16'hFFFE, 1'b1); tick();
      setin(16'hFF02, 16'h0, 1'b0);
      check("cyc_load", Data_out, 16'hFFFE);
      tick(); check("cyc_ffff", Data_out, 16'hFFFF);
      tick(); check("cyc_wrap", Data_out, 16'h0000);

`ifdef DMEM_IO_TIMER_EN
      setin(16'hFF03, 16'd3, 1'b1); tick();
      setin(16'hFF03, 16'h0, 1'b0);
      check("tmr_3", Data_out, 16'd3);
      check("tmr_irq_lo", {15'd0, Timer_irq}, 16'd0);
      tick(); check("tmr_2", Data_out, 16'd2);
      tick(); check("tmr_1", Data_out, 16'd1);
      tick(); check("tmr_0", Data_out, 16'd0);
      check("tmr_irq_hi", {15'd0, Timer_irq}, 16'd1);
      tick(); check("tmr_irq_hold", {15'd0, Timer_irq}, 16'd1);
      setin(16'hFF04, 16'h0, 1'b0);
      check("tmr_stat", Data_out, 16'h0001);
      setin(16'hFF04, 16'h0001, 1'b1); tick();
      check("tmr_clear", {15'd0, Timer_irq}, 16'd0);
      setin(16'hFF04, 16'h0002, 1'b1); tick();
      setin(16'hFF03, 16'd3, 1'b1); tick();
      setin(16'hFF03, 16'h0, 1'b0);
      tick(); tick();
      check("auto_pre", {15'd0, Timer_irq}, 16'd0);
      tick();
      check("auto_fire", {15'd0, Timer_irq}, 16'd1);
      check("auto_reload", Data_out, 16'd3);
      setin(16'hFF04, 16'h0003, 1'b1); tick();
      check("auto_clr", {15'd0, Timer_irq}, 16'd0);
      setin(16'hFF03, 16'h0, 1'b0); tick();
      setin(16'hFF04, 16'h0003, 1'b1); tick();
      check("set_wins", {15'd0, Timer_irq}, 16'd1);
      setin(16'hFF03, 16'h0, 1'b1); tick();
      setin(16'hFF04, 16'h0001, 1'b1); tick();
      setin(16'hFF03, 16'h0001, 1'b1); tick();
      setin(16'hFF03, 16'h0, 1'b0); tick();
      check("pre_rst_irq", {15'd0, Timer_irq}, 16'd1);
`else
      setin(16'hFF03, 16'd3, 1'b1); tick();
      setin(16'hFF03, 16'h0, 1'b0);
      check("notmr_load", Data_out, 16'h0000);
      setin(16'hFF04, 16'h0, 1'b0);
      check("notmr_stat", Data_out, 16'h0000);
      check("notmr_irq", {15'd0, Timer_irq}, 16'd0);
`endif

      // async reset during a LED write
      check("pre_rst_led", Led_out, 16'h00A5);
      setin(16'hFF00, 16'h5A5A, 1'b1);
      #2 Reset = 1'b0;
      #1;
      check("async_led", Led_out, 16'h0000);
      check("async_irq", {15'd0, Timer_irq}, 16'd0);
      @(posedge Clock);
      #1 Reset = 1'b1;
      setin(16'hFF00, 16'h0, 1'b0);
      check("lost_write", Data_out, 16'h0000);
      setin(16'hFF02, 16'h0, 1'b0);
      check("rst_cyc2", Data_out, 16'h0000);
      tick();
      check("first_inc", Data_out, 16'h0001);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] a, d;
         case ($urandom_range(0, 3))
            0, 1:    a = 16'($urandom_range(0, 3) * 256 + $urandom_range(0, 31));
            2:       a = 16'hFF00 + 16'($urandom_range(0, 7));
            default: a = 16'hFF00 + 16'($urandom_range(0, 255));
         endcase
         d = 16'($urandom_range(0, 16'hFFFF));
         if (a == 16'hFF03) d = 16'($urandom_range(0, 6));
         if ($urandom_range(0, 7) == 0) Switch_in = 16'($urandom_range(0, 16'hFFFF));
         setin(a, d, ($urandom_range(0, 2) == 0));
         if ($urandom_range(0, 400) == 0) begin
            #2 Reset = 1'b0;
         end
         tick();
         if (!Reset) Reset = 1'b1;
      end

      run_cmp = 1'b0;
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
